// File: rtl/mul_io_pkg.sv
// mul_io_pkg: shared state type and defaults for mul_io_ctrl
package mul_io_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_MUL_LAT = 2;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mul_io_ctrl_lat_counter.sv
// lat_counter: loadable down-counter whose terminal count flags the final busy cycle
module lat_counter import mul_io_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge clk)
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - CNT_W'(1);
  assign tc = cnt == CNT_W'(1);
endmodule

// File: rtl/mul_io_ctrl.sv
// mul_io_ctrl: valid/ready wrapper around an external fixed-latency multiplier
module mul_io_ctrl import mul_io_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);
  state_t state, state_next;
  logic accept, capture, tc;
  logic [CNT_W-1:0] cnt;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign capture = state == BUSY && tc;
  assign out_valid = state == DONE;
  lat_counter u_cnt (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .load_val(CNT_W'(MUL_LAT)),
    .dec(state == BUSY),
    .cnt(cnt),
    .tc(tc)
  );
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (accept) state_next = BUSY;
    else if (capture) state_next = DONE;
    else if (state == DONE && out_ready) state_next = IDLE;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      mul_a <= '0;
      mul_b <= '0;
      out_p <= '0;
    end else begin
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      if (capture) out_p <= mul_p;
    end
endmodule

// File: tb/tb_mul_io_ctrl.sv
// tb_mul_io_ctrl: scoreboard bench driving three latency variants with directed and random traffic
module tb_mul_io_ctrl;
  logic clk = 0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0, done_cnt = 0;
  typedef struct {
    logic [31:0] a, b;
    logic [63:0] p;
    time t;
  } exp_t;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    logic reset = 0, in_valid = 0, out_ready = 0, in_ready, out_valid;
    logic [31:0] in_a = 0, in_b = 0, mul_a, mul_b;
    logic [63:0] mul_p = 0, out_p;
    bit force36 = 0, ev;
    exp_t q[$];
    mul_io_ctrl #(.WIDTH(32), .MUL_LAT(L)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
    );
    task automatic c(input string n, input logic [63:0] act, input logic [63:0] exp);
      chk($sformatf("L%0d %s", L, n), act, exp);
    endtask
    // mul_p carries the true product only in the cycle before the capture edge
    task automatic drive(input bit r, input bit iv, input logic [31:0] x, input logic [31:0] y, input bit ordy);
      bit acc;
      reset = r;
      in_valid = iv;
      in_a = x;
      in_b = y;
      out_ready = ordy;
      mul_p = force36 ? 64'd36 :
              (q.size() > 0 && ($time - 1 - q[0].t) == time'((L - 1) * 10)) ? {32'd0, mul_a} * {32'd0, mul_b} :
              {$urandom, $urandom};
      #1 acc = r && iv && in_ready;
      @(posedge clk);
      if (!r) q.delete();
      else if (acc) q.push_back('{a: x, b: y, p: {32'd0, x} * {32'd0, y}, t: $time});
      #1;
    endtask
    task automatic rst_chk();
      c("rst out_valid", out_valid, 0);
      c("rst out_p", out_p, 0);
      c("rst mul_a", mul_a, 0);
      c("rst mul_b", mul_b, 0);
      c("rst in_ready", in_ready, 1);
    endtask
    always @(negedge clk)
      if (reset) begin
        ev = q.size() > 0 && ($time - q[0].t) > time'(L * 10);
        c("out_valid", out_valid, ev);
        c("in_ready", in_ready, q.size() == 0 || (ev && out_ready));
        if (q.size() > 0) begin
          c("mul_a", mul_a, q[0].a);
          c("mul_b", mul_b, q[0].b);
        end
        if (ev) begin
          c("out_p", out_p, q[0].p);
          if (out_ready) void'(q.pop_front());
        end
      end
    initial begin
      logic [31:0] a, b;
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      rst_chk();
      drive(1, 1, 3, 5, 1);
      repeat (L + 2) drive(1, 0, 0, 0, 1);
      drive(1, 1, '1, '1, 1);
      repeat (L + 2) drive(1, 0, 0, 0, 1);
      drive(1, 1, 7, 9, 0);
      repeat (L + 5) drive(1, 1, $urandom, $urandom, 0);
      drive(1, 1, 2, 4, 1);
      repeat (L + 2) drive(1, 0, 0, 0, 1);
      drive(1, 1, 6, 6, 0);
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      rst_chk();
      force36 = 1;
      repeat (L + 2) drive(1, 0, 0, 0, 1);
      c("late mul_p out_p", out_p, 0);
      force36 = 0;
      for (int i = 0; i < 300; i++) begin
        a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        drive($urandom_range(0, 80) != 0, $urandom_range(0, 1) == 1, a, b, $urandom_range(0, 3) != 0);
      end
      repeat (L + 3) drive(1, 0, 0, 0, 1);
      c("drain", q.size(), 0);
      done_cnt++;
    end
  end
  initial begin
    for (int i = 0; i < 20000 && done_cnt < 3; i++) @(posedge clk);
    tests++;
    if (done_cnt < 3) begin
      fails++;
      $display("FAIL timeout: %0d of 3 lanes finished", done_cnt);
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_io_ctrl.md
MUL_IO_CTRL -- requirements
Module: mul_io_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 The block SHALL have parameter MUL_LAT, default 2, multiplier latency in cycles (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operand pair offered.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-007 The block SHALL have ports in_a and in_b, input, WIDTH each, unsigned operands.
REQ-008 The block SHALL have ports mul_a and mul_b, output, WIDTH each, registered operands to the external multiplier.
REQ-009 The block SHALL have port mul_p, input, 2*WIDTH, unsigned product from the external multiplier.
REQ-010 The block SHALL have port out_valid, output, 1, result available.
REQ-011 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-012 The block SHALL have port out_p, output, 2*WIDTH, registered product.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 in IDLE, equal out_ready in DONE, and 0 in BUSY.
REQ-015 An input handshake (in_valid & in_ready at an edge) SHALL load in_a/in_b into the mul_a/mul_b registers, load the latency counter with MUL_LAT, and enter BUSY.
REQ-016 mul_a/mul_b SHALL hold their value until the next input handshake, with no glitching during BUSY.
REQ-017 In BUSY, the counter SHALL decrement each cycle; at the edge where the counter equals 1, out_p SHALL capture mul_p, out_valid SHALL rise, and the state SHALL become DONE.
REQ-018 out_valid SHALL therefore first be high exactly MUL_LAT cycles after the acceptance edge.
REQ-019 In DONE, out_valid SHALL stay 1 and out_p SHALL stay stable until out_ready=1 at an edge.
REQ-020 In DONE, out_ready=1 with in_valid=0 SHALL drop out_valid and return to IDLE.
REQ-021 In DONE, out_ready=1 with in_valid=1 SHALL complete both handshakes at the same edge and enter BUSY with the new operands (back-to-back, no bubble).
REQ-022 in_valid SHALL be ignored in BUSY, and in DONE while out_ready=0.
REQ-023 mul_p SHALL be sampled only at the REQ-017 edge; mul_p values in other cycles SHALL have no effect.
REQ-024 No arithmetic SHALL be performed on the data path; the product width SHALL be exactly 2*WIDTH with no truncation.

Reset
REQ-025 With reset=0 at an edge, the state SHALL become IDLE, the counter 0, mul_a/mul_b 0, out_p 0 and out_valid 0; in_ready SHALL then be 1.
REQ-026 Reset SHALL override every handshake in the same cycle, including a reset asserted in BUSY or DONE; an in-flight product SHALL be discarded.
REQ-027 Reset SHALL act only at clock edges; there SHALL be no asynchronous path.

Structure
REQ-028 Package mul_io_pkg SHALL hold the state enum (IDLE/BUSY/DONE), default WIDTH, default MUL_LAT and the counter width constant (4 bits).
REQ-029 The latency counter SHALL be a sub-module lat_counter (load, decrement, terminal-count output, synchronous active-low reset).
REQ-030 The FSM and the operand/result registers SHALL reside in mul_io_ctrl; the multiplier SHALL remain outside the block.

Verification
REQ-031 Scenario: MUL_LAT=2, ideal multiplier model, in_a=3, in_b=5, out_ready=1 -> out_valid high 2 cycles after acceptance, out_p=15, then IDLE.
REQ-032 Scenario: in_a=in_b=0xFFFFFFFF -> out_p=0xFFFFFFFE00000001.
REQ-033 Scenario: result 7*9, out_ready held 0 for 5 cycles -> out_valid stays 1, out_p=63 stable, in_ready=0; release -> IDLE.
REQ-034 Scenario: in DONE with out_p=63, out_ready=1 and in_valid=1 with 2*4 in the same cycle -> both handshakes occur; next out_p=8 after MUL_LAT cycles, no idle cycle.
REQ-035 Scenario: reset=0 in the second BUSY cycle of 6*6 -> next cycle IDLE, out_valid=0, out_p=0, mul_a=mul_b=0; a late mul_p=36 is never captured.
REQ-036 Scenario: MUL_LAT=1 and MUL_LAT=15 sweep with random operands against a reference model -> out_valid latency equals MUL_LAT and products match.
